snax_mem_arbiter: RTL
=====================

# snax_mem_arbiter

Round-robin arbiter that shares the single-port SRAM macro behind the cluster-level `axi_to_mem` path between several mem-protocol requesters, e.g. the AXI-to-mem converter and a preload/debug port. It grants one request per cycle, respects SRAM backpressure and an outstanding-request credit limit, and routes each in-order SRAM response back to its originating requester through a tag FIFO. It sits between the mem-side converters and `spm_1p_adv` in the FPGA top.

## Interface
- `NumReq`, 2: number of requesters; must be ≥2.
- `AddrWidth`, 48: requester byte-address width.
- `DataWidth`, 64: data width; byte strobe width is `DataWidth/8`.
- `SramAddrWidth`, 16: SRAM word-address width.
- `MaxOutstanding`, 4: maximum number of granted requests awaiting `sram_rvalid_i`; must be a power of two, ≥2.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in `NumReq`: request valid, one per requester.
- `gnt_o` out `NumReq`: grant, one-hot or zero.
- `addr_i` in `NumReq`×`AddrWidth`: byte address.
- `we_i` in `NumReq`: 1 = write.
- `wdata_i` in `NumReq`×`DataWidth`: write data.
- `strb_i` in `NumReq`×`DataWidth/8`: byte enables.
- `rvalid_o` out `NumReq`: response valid, for reads and writes.
- `rdata_o` out `NumReq`×`DataWidth`: read data, broadcast to all requesters and qualified by `rvalid_o`.
- `sram_valid_o` out 1, `sram_ready_i` in 1: SRAM request handshake.
- `sram_we_o` out 1, `sram_addr_o` out `SramAddrWidth`, `sram_wdata_o` out `DataWidth`, `sram_be_o` out `DataWidth/8`: SRAM request fields.
- `sram_rvalid_i` in 1, `sram_rdata_i` in `DataWidth`: in-order SRAM response, one per accepted request.
- `stall_cnt_o` out 32: cycles in which at least one `req_i` was high but no grant was given. Saturates at `32'hFFFF_FFFF`.
- `err_o` out 1: sticky flag, set when `sram_rvalid_i` arrives with no outstanding tag.

## Operation
- Eligibility: `req_i[i]` is high, `sram_ready_i` is high, and `credit = outstanding < MaxOutstanding`.
- Round-robin selection: the winner is the first eligible index at or after pointer `rr_q`, searching cyclically.
- On a grant to index i:
  - Assert `gnt_o[i]` and `sram_valid_o`.
  - Drive the selected `we`, `strb` and `wdata`.
  - Set `sram_addr_o = addr_i[i][SramAddrWidth+$clog2(DataWidth/8)-1 : $clog2(DataWidth/8)]`. Upper address bits are ignored, so addresses alias.
  - Push i into the tag FIFO and set `rr_q <= (i+1) mod NumReq`.
- With no winner: `sram_valid_o` = 0, `gnt_o` = 0, `rr_q` holds.
- `sram_valid_o` is asserted only when a winner exists. `sram_valid_o` and `gnt_o` depend combinationally on `sram_ready_i`.
- On `sram_rvalid_i`:
  - Pop the FIFO head h.
  - Assert `rvalid_o[h]` in the same cycle, with `rdata_o = sram_rdata_i`.
  - Requesters cannot stall responses.
- Credit is full when `outstanding == MaxOutstanding`. No grant is given that cycle, even if `sram_rvalid_i` is high; the credit limit is conservative.
- Push and pop in the same cycle: `outstanding` is unchanged and the FIFO stays consistent.
- `sram_rvalid_i` with an empty FIFO: the response is dropped, all `rvalid_o` stay 0, and `err_o` is set. `err_o` clears only on reset.
- `stall_cnt_o` increments whenever `|req_i` is high and `gnt_o == 0`, whether the cause is SRAM backpressure or the credit limit.

## Timing
- Grant latency: 0 cycles. A request is granted combinationally in the cycle it is eligible and wins.
- Response latency: equal to the SRAM's latency, plus 0 cycles through the arbiter. `rvalid_o` is combinational from `sram_rvalid_i`.
- Reset values: `rr_q` = 0, FIFO empty, `outstanding` = 0, `stall_cnt_o` = 0, `err_o` = 0. All outputs are 0 during reset.
- Reset mid-operation clears all tags. The SRAM must be reset in the same cycle so that no stale response returns.

## Structure
- Shared package `snax_mem_arb_pkg` holds:
  - `mem_req_t` (addr/we/wdata/strb),
  - `mem_rsp_t` (rvalid/rdata),
  - `tag_t = logic [$clog2(NumReq)-1:0]`.
- One sub-module, `snax_mem_arb_tag_fifo`: a `MaxOutstanding`-deep FIFO of `tag_t` with synchronous active-high reset. It provides wrap-around read/write pointers, a count output, and full/empty flags.

## Test plan
- Single requester: req0 writes `0xDEADBEEF_CAFEF00D` to address `0x8000_0010`, then reads the same address. Required: `sram_addr_o` = 2 for both. The write completes with `rvalid_o[0]`. The read returns the data on `rvalid_o[0]` only.
- Both requesters hold `req_i` continuously with `sram_ready_i` = 1. Required: grants alternate 0,1,0,1…, and responses route to the matching requester in order.
- SRAM holds responses with `MaxOutstanding` = 4. Required: exactly 4 grants, then `gnt_o` = 0 and `stall_cnt_o` increments each cycle. One `sram_rvalid_i` pulse re-enables a grant on the next cycle.
- `sram_ready_i` = 0 for 3 cycles with `req_i` = 2'b11. Required: no grant, `stall_cnt_o` increases by 3, and `rr_q` is unchanged.
- Spurious `sram_rvalid_i` with an empty FIFO. Required: `rvalid_o` = 0 and `err_o` = 1 and stays set. `rst_i` clears it.
- Assert `rst_i` with 3 requests outstanding. Required: the next cycle shows `outstanding` = 0 and `gnt_o` = 0, and grants restart from requester 0.

Source files
------------

// File: rtl/snax_mem_arb_pkg.sv
// snax_mem_arbiter shared types.
// Default widths, request/response bundles, requester tag type.
package snax_mem_arb_pkg;

  localparam int NumReqDef    = 2;
  localparam int AddrWidthDef = 48;
  localparam int DataWidthDef = 64;
  localparam int StrbWidthDef = DataWidthDef / 8;

  typedef logic [$clog2(NumReqDef)-1:0] tag_t;

  typedef struct packed {
    logic [AddrWidthDef-1:0] addr;
    logic                    we;
    logic [DataWidthDef-1:0] wdata;
    logic [StrbWidthDef-1:0] strb;
  } mem_req_t;

  typedef struct packed {
    logic                    rvalid;
    logic [DataWidthDef-1:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/snax_mem_arbiter_if.sv
// Requester-side mem bundle of snax_mem_arbiter.
// master: requesters (req/addr/we/wdata/strb out), slave: arbiter.
interface snax_mem_arbiter_if #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 48,
  parameter int DataWidth = 64
);

  localparam int StrbWidth = DataWidth / 8;

  logic [NumReq-1:0]                req_i;
  logic [NumReq-1:0]                gnt_o;
  logic [NumReq-1:0][AddrWidth-1:0] addr_i;
  logic [NumReq-1:0]                we_i;
  logic [NumReq-1:0][DataWidth-1:0] wdata_i;
  logic [NumReq-1:0][StrbWidth-1:0] strb_i;
  logic [NumReq-1:0]                rvalid_o;
  logic [NumReq-1:0][DataWidth-1:0] rdata_o;

  modport master (
    output req_i, addr_i, we_i, wdata_i, strb_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, wdata_i, strb_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/snax_mem_arb_tag_fifo.sv
// Tag FIFO: remembers which requester owns each in-flight SRAM access.
// Ports: clk_i, rst_i (sync high), push_i/data_i, pop_i/data_o, count_o, full_o, empty_o.
module snax_mem_arb_tag_fifo
  import snax_mem_arb_pkg::*;
#(
  parameter int  Depth  = 4,
  parameter type data_t = tag_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  data_t                  data_i,
  input  logic                   pop_i,
  output data_t                  data_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PtrW = $clog2(Depth);

  data_t             mem_q [Depth];
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [PtrW:0]     cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/snax_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between mem requesters.
// Ports: clk_i, rst_i, req_if (slave), sram_* request/response, stall_cnt_o, err_o.
module snax_mem_arbiter
  import snax_mem_arb_pkg::*;
#(
  parameter int NumReq         = NumReqDef,
  parameter int AddrWidth      = AddrWidthDef,
  parameter int DataWidth      = DataWidthDef,
  parameter int SramAddrWidth  = 16,
  parameter int MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  snax_mem_arbiter_if.slave        req_if,
  output logic                     sram_valid_o,
  input  logic                     sram_ready_i,
  output logic                     sram_we_o,
  output logic [SramAddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [DataWidth/8-1:0]   sram_be_o,
  input  logic                     sram_rvalid_i,
  input  logic [DataWidth-1:0]     sram_rdata_i,
  output logic [31:0]              stall_cnt_o,
  output logic                     err_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int Off       = $clog2(StrbWidth);
  localparam int TagW      = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW      = $clog2(MaxOutstanding) + 1;

  typedef logic [TagW-1:0] idx_t;

  logic [NumReq-1:0] elig;
  logic              credit;
  logic              win;
  idx_t              win_idx;
  idx_t              rr_q;
  idx_t              head;
  int                idx;
  logic              pop;
  logic [CntW-1:0]   fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       stall_q;
  logic              err_q;
  logic              unused_misc;

  assign unused_misc = ^{req_if.addr_i, fifo_full};

  // Full credit blocks grants even if a response retires this cycle.
  assign credit = int'(fifo_cnt) < MaxOutstanding;
  assign elig   = req_if.req_i
                & {NumReq{sram_ready_i & credit & ~rst_i}};

  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!win && elig[idx_t'(idx)]) begin
        win     = 1'b1;
        win_idx = idx_t'(idx);
      end
    end
  end

  always_comb begin
    req_if.gnt_o = '0;
    sram_valid_o = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (win) begin
      req_if.gnt_o[win_idx] = 1'b1;
      sram_valid_o = 1'b1;
      sram_we_o    = req_if.we_i[win_idx];
      sram_addr_o  = req_if.addr_i[win_idx][Off +: SramAddrWidth];
      sram_wdata_o = req_if.wdata_i[win_idx];
      sram_be_o    = req_if.strb_i[win_idx];
    end
  end

  // Responses cannot be back-pressured; route straight to the head tag.
  assign pop = sram_rvalid_i & ~fifo_empty & ~rst_i;

  always_comb begin
    req_if.rvalid_o = '0;
    if (pop) req_if.rvalid_o[head] = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      req_if.rdata_o[i] = rst_i ? '0 : sram_rdata_i;
    end
  end

  snax_mem_arb_tag_fifo #(
    .Depth  (MaxOutstanding),
    .data_t (idx_t)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (win),
    .data_i  (win_idx),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q    <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (win) begin
        rr_q <= (int'(win_idx) == NumReq - 1) ? '0 : win_idx + 1'b1;
      end
      if ((|req_if.req_i) && !win && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (sram_rvalid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign stall_cnt_o = rst_i ? '0 : stall_q;
  assign err_o       = rst_i ? 1'b0 : err_q;

endmodule
